// File: rtl/pingpong_addr_ctrl.sv
// Address and bank-select generator for a two-bank ping-pong RAM.
// The writer fills one bank while the reader drains the other; the banks swap once both sides are done.
module pingpong_addr_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clock_in,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_add,
  output logic              r_en,
  output logic [ADDR_W-1:0] r_add,
  input  logic              out_ready,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              swich_ctrl,
  output logic              swap_pulse,
  output logic [7:0]        frame_cnt
);

  // Handshake: a word moves on w_en = in_valid & in_ready, and a read issues
  // on r_en = rd_busy & out_ready. out_ready gates issue only; the consumer
  // must take rd_valid data unconditionally RD_LAT cycles later.

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic              swich_q, swich_d;
  logic [ADDR_W-1:0] w_add_q, w_add_d;
  logic [ADDR_W-1:0] r_add_q, r_add_d;
  logic              wr_full_q, wr_full_d;
  logic              rd_busy_q, rd_busy_d;
  logic              swap_pulse_q;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] last_q;

  logic swap;
  logic w_last;
  logic r_last;

  assign in_ready = ~wr_full_q;
  assign w_en     = in_valid & ~wr_full_q;
  assign r_en     = rd_busy_q & out_ready;
  assign w_last   = w_en && (w_add_q == LAST_ADDR);
  assign r_last   = r_en && (r_add_q == LAST_ADDR);

  // A swap needs wr_full=1 (so no write) and rd_busy=0 (so no read) in the
  // same cycle, which keeps swich_ctrl stable whenever a strobe is active.
  assign swap = wr_full_q & ~rd_busy_q;

  always_comb begin
    swich_d     = swich_q;
    w_add_d     = w_add_q;
    r_add_d     = r_add_q;
    wr_full_d   = wr_full_q;
    rd_busy_d   = rd_busy_q;
    frame_cnt_d = frame_cnt_q;
    if (w_en) begin
      w_add_d = w_add_q + 1'b1;
      if (w_last) wr_full_d = 1'b1;
    end
    if (r_en) begin
      r_add_d = r_add_q + 1'b1;
      if (r_last) rd_busy_d = 1'b0;
    end
    if (swap) begin
      swich_d     = ~swich_q;
      wr_full_d   = 1'b0;
      rd_busy_d   = 1'b1;
      w_add_d     = '0;
      r_add_d     = '0;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (!rst_n) begin
      swich_q      <= 1'b1;
      w_add_q      <= '0;
      r_add_q      <= '0;
      wr_full_q    <= 1'b0;
      rd_busy_q    <= 1'b0;
      swap_pulse_q <= 1'b0;
      frame_cnt_q  <= '0;
      vld_q        <= '0;
      last_q       <= '0;
    end else begin
      swich_q      <= swich_d;
      w_add_q      <= w_add_d;
      r_add_q      <= r_add_d;
      wr_full_q    <= wr_full_d;
      rd_busy_q    <= rd_busy_d;
      swap_pulse_q <= swap;
      frame_cnt_q  <= frame_cnt_d;
      vld_q[0]     <= r_en;
      last_q[0]    <= r_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  assign w_add      = w_add_q;
  assign r_add      = r_add_q;
  assign swich_ctrl = swich_q;
  assign swap_pulse = swap_pulse_q;
  assign frame_cnt  = frame_cnt_q;
  assign rd_valid   = vld_q[RD_LAT-1];
  assign rd_last    = last_q[RD_LAT-1];

endmodule

// File: tb/tb_pingpong_addr_ctrl.sv
// Directed bench for pingpong_addr_ctrl; u1 uses RD_LAT=1, u2 uses RD_LAT=2 on the same inputs.
module tb_pingpong_addr_ctrl;

  logic clock_in = 1'b0;
  logic rst_n, in_valid, out_ready;

  logic       in_ready1, w_en1, r_en1, rd_valid1, rd_last1, swich1, swap_pulse1;
  logic [3:0] w_add1, r_add1;
  logic [7:0] frame_cnt1;
  logic       in_ready2, w_en2, r_en2, rd_valid2, rd_last2, swich2, swap_pulse2;
  logic [3:0] w_add2, r_add2;
  logic [7:0] frame_cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clock_in = ~clock_in;

  pingpong_addr_ctrl #(.ADDR_W(4), .DEPTH(16), .RD_LAT(1)) u1 (
    .clock_in(clock_in), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .w_en(w_en1), .w_add(w_add1), .r_en(r_en1), .r_add(r_add1), .out_ready(out_ready),
    .rd_valid(rd_valid1), .rd_last(rd_last1), .swich_ctrl(swich1),
    .swap_pulse(swap_pulse1), .frame_cnt(frame_cnt1)
  );

  pingpong_addr_ctrl #(.ADDR_W(4), .DEPTH(16), .RD_LAT(2)) u2 (
    .clock_in(clock_in), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .w_en(w_en2), .w_add(w_add2), .r_en(r_en2), .r_add(r_add2), .out_ready(out_ready),
    .rd_valid(rd_valid2), .rd_last(rd_last2), .swich_ctrl(swich2),
    .swap_pulse(swap_pulse2), .frame_cnt(frame_cnt2)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); settle();
    tests++; if (swich1 !== 1'b1) begin fails++; $display("FAIL reset_swich got %b exp 1", swich1); end
    tests++; if (w_add1 !== 4'd0) begin fails++; $display("FAIL reset_w_add got %0d exp 0", w_add1); end
    tests++; if (r_add1 !== 4'd0) begin fails++; $display("FAIL reset_r_add got %0d exp 0", r_add1); end
    tests++; if (in_ready1 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready1); end
    tests++; if (r_en1 !== 1'b0) begin fails++; $display("FAIL reset_r_en got %b exp 0", r_en1); end
    tests++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %b/%b exp 0/0", rd_valid1, rd_valid2); end
    tests++; if (swap_pulse1 !== 1'b0) begin fails++; $display("FAIL reset_swap_pulse got %b exp 0", swap_pulse1); end
    tests++; if (frame_cnt1 !== 8'd0) begin fails++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt1); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill_and_swap();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      settle();
      tests++; if (w_add1 !== 4'(i) || w_en1 !== 1'b1) begin fails++; $display("FAIL fill_write i=%0d got add %0d en %b exp add %0d en 1", i, w_add1, w_en1, i); end
      tests++; if (r_en1 !== 1'b0) begin fails++; $display("FAIL fill_no_read i=%0d got %b exp 0", i, r_en1); end
      tick();
    end
    settle();
    tests++; if (in_ready1 !== 1'b0 || w_en1 !== 1'b0) begin fails++; $display("FAIL full_in_ready got rdy %b en %b exp 0 0", in_ready1, w_en1); end
    tests++; if (r_en1 !== 1'b0 || swich1 !== 1'b1) begin fails++; $display("FAIL swap_cond got r_en %b swich %b exp 0 1", r_en1, swich1); end
    tick(); settle();
    tests++; if (swich1 !== 1'b0 || swap_pulse1 !== 1'b1) begin fails++; $display("FAIL first_swap got swich %b pulse %b exp 0 1", swich1, swap_pulse1); end
    tests++; if (frame_cnt1 !== 8'd1) begin fails++; $display("FAIL first_frame_cnt got %0d exp 1", frame_cnt1); end
    for (int j = 0; j < 16; j++) begin
      settle();
      tests++; if (r_add1 !== 4'(j) || r_en1 !== 1'b1) begin fails++; $display("FAIL drain_read j=%0d got add %0d en %b exp add %0d en 1", j, r_add1, r_en1, j); end
      tests++; if (w_add1 !== 4'(j) || w_en1 !== 1'b1) begin fails++; $display("FAIL drain_write j=%0d got add %0d en %b exp add %0d en 1", j, w_add1, w_en1, j); end
      tests++; if (rd_valid1 !== (j != 0) || rd_last1 !== 1'b0) begin fails++; $display("FAIL drain_valid1 j=%0d got v %b l %b exp v %b l 0", j, rd_valid1, rd_last1, (j != 0)); end
      tests++; if (rd_valid2 !== (j >= 2)) begin fails++; $display("FAIL drain_valid2 j=%0d got %b exp %b", j, rd_valid2, (j >= 2)); end
      tick();
    end
  endtask

  // Continues from test_fill_and_swap: last write and last read landed on the same edge.
  task automatic test_simultaneous();
    settle();
    tests++; if (rd_valid1 !== 1'b1 || rd_last1 !== 1'b1) begin fails++; $display("FAIL sim_last1 got v %b l %b exp 1 1", rd_valid1, rd_last1); end
    tests++; if (rd_valid2 !== 1'b1 || rd_last2 !== 1'b0) begin fails++; $display("FAIL sim_last2_early got v %b l %b exp 1 0", rd_valid2, rd_last2); end
    tests++; if (in_ready1 !== 1'b0 || r_en1 !== 1'b0 || swich1 !== 1'b0) begin fails++; $display("FAIL sim_cond got rdy %b r_en %b swich %b exp 0 0 0", in_ready1, r_en1, swich1); end
    tests++; if (w_add1 !== 4'd0 || r_add1 !== 4'd0) begin fails++; $display("FAIL sim_addr got w %0d r %0d exp 0 0", w_add1, r_add1); end
    tick(); settle();
    tests++; if (swich1 !== 1'b1 || swap_pulse1 !== 1'b1 || frame_cnt1 !== 8'd2) begin fails++; $display("FAIL sim_swap got swich %b pulse %b cnt %0d exp 1 1 2", swich1, swap_pulse1, frame_cnt1); end
    tests++; if (w_en1 !== 1'b1 || w_add1 !== 4'd0 || r_en1 !== 1'b1 || r_add1 !== 4'd0) begin fails++; $display("FAIL sim_restart got w %b/%0d r %b/%0d exp 1/0 1/0", w_en1, w_add1, r_en1, r_add1); end
    tests++; if (rd_valid1 !== 1'b0) begin fails++; $display("FAIL sim_gap1 got %b exp 0", rd_valid1); end
    tests++; if (rd_valid2 !== 1'b1 || rd_last2 !== 1'b1) begin fails++; $display("FAIL sim_last2 got v %b l %b exp 1 1", rd_valid2, rd_last2); end
    tick(); settle();
    tests++; if (w_add1 !== 4'd1 || r_add1 !== 4'd1 || swap_pulse1 !== 1'b0) begin fails++; $display("FAIL sim_next got w %0d r %0d pulse %b exp 1 1 0", w_add1, r_add1, swap_pulse1); end
  endtask

  task automatic test_continuous();
    int nswap = 0, nvalid = 0, nw = 0, nr = 0;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 200 && nswap < 5; c++) begin
      settle();
      if (rd_valid1) nvalid++;
      if (w_en1) nw++;
      if (r_en1) nr++;
      if (swap_pulse1) begin
        nswap++;
        tests++; if (c != 17 * nswap) begin fails++; $display("FAIL cont_swap_cycle swap %0d got cycle %0d exp %0d", nswap, c, 17 * nswap); end
        tests++; if (swich1 !== 1'(nswap % 2 == 0)) begin fails++; $display("FAIL cont_swich swap %0d got %b exp %b", nswap, swich1, (nswap % 2 == 0)); end
      end
      if (nswap < 5) tick();
    end
    tests++; if (nswap != 5) begin fails++; $display("FAIL cont_timeout got %0d swaps exp 5", nswap); end
    tests++; if (frame_cnt1 !== 8'd5) begin fails++; $display("FAIL cont_frame_cnt got %0d exp 5", frame_cnt1); end
    tests++; if (nvalid != 64) begin fails++; $display("FAIL cont_rd_valid got %0d exp 64", nvalid); end
    tests++; if (nw != 81 || nr != 65) begin fails++; $display("FAIL cont_idle got writes %0d reads %0d exp 81 65", nw, nr); end
  endtask

  task automatic test_reader_stall();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (25) tick();
    out_ready = 1'b0;
    for (int c = 25; c < 40; c++) begin
      settle();
      tests++; if (r_en1 !== 1'b0 || r_add1 !== 4'd8) begin fails++; $display("FAIL stall_read c=%0d got en %b add %0d exp 0 8", c, r_en1, r_add1); end
      if (c >= 33) begin
        tests++; if (in_ready1 !== 1'b0 || w_add1 !== 4'd0 || swich1 !== 1'b0 || swap_pulse1 !== 1'b0) begin fails++; $display("FAIL stall_hold c=%0d got rdy %b w %0d swich %b pulse %b exp 0 0 0 0", c, in_ready1, w_add1, swich1, swap_pulse1); end
      end
      tick();
    end
    out_ready = 1'b1;
    for (int c = 40; c < 48; c++) begin
      settle();
      tests++; if (r_en1 !== 1'b1 || r_add1 !== 4'(c - 32)) begin fails++; $display("FAIL stall_resume c=%0d got en %b add %0d exp 1 %0d", c, r_en1, r_add1, c - 32); end
      tick();
    end
    settle();
    tests++; if (r_en1 !== 1'b0 || in_ready1 !== 1'b0 || swich1 !== 1'b0) begin fails++; $display("FAIL stall_cond got r_en %b rdy %b swich %b exp 0 0 0", r_en1, in_ready1, swich1); end
    tick(); settle();
    tests++; if (swich1 !== 1'b1 || swap_pulse1 !== 1'b1 || frame_cnt1 !== 8'd2) begin fails++; $display("FAIL stall_swap got swich %b pulse %b cnt %0d exp 1 1 2", swich1, swap_pulse1, frame_cnt1); end
  endtask

  task automatic test_slow_writer();
    int nr = 0, stray = 0;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (17) tick();
    for (int c = 17; c < 80; c++) begin
      in_valid = ((c - 17) % 4 == 0);
      settle();
      if (c < 79 && r_en1) nr++;
      if (c > 33 && c < 79 && rd_valid1) stray++;
      if (c == 33) begin
        tests++; if (rd_valid1 !== 1'b1 || rd_last1 !== 1'b1 || r_en1 !== 1'b0) begin fails++; $display("FAIL slow_drain_end got v %b l %b r_en %b exp 1 1 0", rd_valid1, rd_last1, r_en1); end
      end
      if (c == 78) begin
        tests++; if (in_ready1 !== 1'b0 || w_add1 !== 4'd0 || swich1 !== 1'b0) begin fails++; $display("FAIL slow_full got rdy %b w %0d swich %b exp 0 0 0", in_ready1, w_add1, swich1); end
      end
      if (c == 79) begin
        tests++; if (swap_pulse1 !== 1'b1 || swich1 !== 1'b1 || frame_cnt1 !== 8'd2) begin fails++; $display("FAIL slow_swap got pulse %b swich %b cnt %0d exp 1 1 2", swap_pulse1, swich1, frame_cnt1); end
      end
      tick();
    end
    tests++; if (nr != 16) begin fails++; $display("FAIL slow_read_count got %0d exp 16", nr); end
    tests++; if (stray != 0) begin fails++; $display("FAIL slow_stray_valid got %0d exp 0", stray); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (17) tick();
    in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1;
    repeat (7) tick();
    settle();
    tests++; if (w_add1 !== 4'd7 || r_add1 !== 4'd9 || w_add2 !== 4'd7 || r_add2 !== 4'd9) begin fails++; $display("FAIL mid_setup got w %0d r %0d exp 7 9", w_add2, r_add2); end
    tests++; if (rd_valid2 !== 1'b1) begin fails++; $display("FAIL mid_inflight got %b exp 1", rd_valid2); end
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      settle();
      tests++; if (rd_valid2 !== 1'b0 || rd_last2 !== 1'b0 || rd_valid1 !== 1'b0) begin fails++; $display("FAIL mid_rst_valid k=%0d got v2 %b l2 %b v1 %b exp 0 0 0", k, rd_valid2, rd_last2, rd_valid1); end
      tests++; if (swich2 !== 1'b1 || frame_cnt2 !== 8'd0 || swap_pulse2 !== 1'b0) begin fails++; $display("FAIL mid_rst_state k=%0d got swich %b cnt %0d pulse %b exp 1 0 0", k, swich2, frame_cnt2, swap_pulse2); end
      tests++; if (w_add2 !== 4'd0 || r_add2 !== 4'd0 || in_ready2 !== 1'b1 || w_en2 !== 1'b1 || r_en2 !== 1'b0) begin fails++; $display("FAIL mid_rst_addr k=%0d got w %0d r %0d rdy %b w_en %b r_en %b exp 0 0 1 1 0", k, w_add2, r_add2, in_ready2, w_en2, r_en2); end
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      tests++; if (rd_valid2 !== 1'b0 || r_en2 !== 1'b0) begin fails++; $display("FAIL mid_post k=%0d got v %b r_en %b exp 0 0", k, rd_valid2, r_en2); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_fill_and_swap();
    test_simultaneous();
    test_continuous();
    test_reader_stall();
    test_slow_writer();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
